phtime_arb: RTL and testbench

//  Round-robin scheduler sharing one phtime multiplier (freq*tcnt -> 27-bit phase) among NCH

---
 rtl/phtime_arb.sv | 174 +++++++++++++++++
 tb/tb_phtime_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phtime_arb.sv
// ---------------------------------------------------------------------------
// phtime_arb
//   Round-robin scheduler that shares one phtime multiplier among NCH
//   requesting channels. At most one freq*tcnt product is issued per clock.
//   Each issue carries a tag with its channel index. The tag is returned with
//   the 27-bit phase result after the fixed pipeline latency LAT.
//
//   Ports
//     clk        system clock, rising edge
//     resetn     asynchronous active-low reset
//     req        per-channel request, held high until granted
//     freq       per-channel frequency word, channel i at [27*i +: 27]
//     tcnt       per-channel time count, channel i at [27*i +: 27]
//     gnt        one-hot grant; operands are sampled in this cycle
//     res_valid  result strobe
//     res_ch     channel index of the result
//     res_phase  (freq*tcnt) mod 2^27 for that channel, zero when not valid
//     busy       any issue still in flight
//     err        sticky mismatch between phtime gate and tag valid
//
// phtime
//   Fixed-latency multiplier with a gate bit travelling alongside the data.
//   It has no reset; its contents are meaningful only where the gate is set.
// ---------------------------------------------------------------------------

module phtime #(
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic [26:0] freq,
    input  logic [26:0] tcnt,
    input  logic        gatein,
    output logic [26:0] phasetime,
    output logic        gateout
);

    logic [26:0]          a_q;
    logic [26:0]          b_q;
    logic [26:0]          prod_lo;
    logic [LAT-1:1][26:0] prod_q;
    logic [LAT-1:0]       gate_q;

    // Only the low 27 bits of the 54-bit product are ever returned.
    // Those bits depend only on the low 27 bits of each operand, so a
    // 27-bit result width gives the wrapped phase directly.
    assign prod_lo = a_q * b_q;

    // The operands are registered first. The product is registered next.
    // The remaining stages only add delay to reach the total latency.
    always_ff @(posedge clk) begin
        a_q       <= freq;
        b_q       <= tcnt;
        prod_q[1] <= prod_lo;
        for (int s = 2; s < LAT; s++) begin
            prod_q[s] <= prod_q[s-1];
        end
        gate_q <= {gate_q[LAT-2:0], gatein};
    end

    assign phasetime = prod_q[LAT-1];
    assign gateout   = gate_q[LAT-1];

endmodule

module phtime_arb #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int LAT = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*27-1:0]    freq,
    input  logic [NCH*27-1:0]    tcnt,
    output logic [NCH-1:0]       gnt,
    output logic                 res_valid,
    output logic [CHW-1:0]       res_ch,
    output logic [26:0]          res_phase,
    output logic                 busy,
    output logic                 err
);

    localparam int INHW = $clog2(LAT + 1);

    logic [CHW-1:0]            ptr_q;
    logic                      grant_any;
    logic [CHW-1:0]            grant_ch;
    logic [26:0]               op_freq;
    logic [26:0]               op_tcnt;
    logic [LAT-1:0]            tag_v;
    logic [LAT-1:0][CHW-1:0]   tag_ch;
    logic [INHW-1:0]           inhibit_q;
    logic [26:0]               phasetime;
    logic                      gateout;

    function automatic int wrap_idx(input int p, input int k);
        return (p + k) % NCH;
    endfunction

    // Search upward from the pointer, with wrap, for the first request.
    // While reset is held, nothing is granted. This keeps the un-reset phtime
    // gate pipe from picking up an issue that has no tag.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        gnt       = '0;
        op_freq   = '0;
        op_tcnt   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (resetn && !grant_any && req[wrap_idx(int'(ptr_q), k)]) begin
                grant_any = 1'b1;
                grant_ch  = CHW'(wrap_idx(int'(ptr_q), k));
                gnt[wrap_idx(int'(ptr_q), k)] = 1'b1;
                op_freq   = freq[27*wrap_idx(int'(ptr_q), k) +: 27];
                op_tcnt   = tcnt[27*wrap_idx(int'(ptr_q), k) +: 27];
            end
        end
    end

    // After a grant, the pointer moves just past the winner. This rotates
    // priority so that a held request cannot starve the other channels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + CHW'(1);
        end
    end

    phtime #(.LAT(LAT)) u_phtime (
        .clk       (clk),
        .freq      (op_freq),
        .tcnt      (op_tcnt),
        .gatein    (grant_any),
        .phasetime (phasetime),
        .gateout   (gateout)
    );

    // The tag pipe runs in lockstep with phtime. The tag is reset,
    // so it decides which phtime outputs are real.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_v  <= '0;
            tag_ch <= '0;
        end else begin
            tag_v     <= {tag_v[LAT-2:0], grant_any};
            tag_ch[0] <= grant_ch;
            for (int s = 1; s < LAT; s++) begin
                tag_ch[s] <= tag_ch[s-1];
            end
        end
    end

    // phtime's gate history survives reset. The comparison is therefore held
    // off until LAT cycles have pushed the stale bits out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inhibit_q <= INHW'(LAT);
            err       <= 1'b0;
        end else begin
            if (inhibit_q != '0) begin
                inhibit_q <= inhibit_q - INHW'(1);
            end else if (gateout != tag_v[LAT-1]) begin
                err <= 1'b1;
            end
        end
    end

    assign res_valid = tag_v[LAT-1];
    assign res_ch    = tag_ch[LAT-1];
    assign res_phase = tag_v[LAT-1] ? phasetime : '0;
    assign busy      = |tag_v;

endmodule

// File: tb/tb_phtime_arb.sv
// ---------------------------------------------------------------------------
// tb_phtime_arb
//   Self-checking bench for phtime_arb. A round-robin reference model keeps a
//   queue of expected results, each with its due cycle. The model is checked
//   against the DUT on every falling edge. Directed sequences pin the model
//   with hand-computed values. Randomized request traffic follows them.
// ---------------------------------------------------------------------------

module tb_phtime_arb;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int LAT = 5;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NCH-1:0]       req;
    logic [NCH*27-1:0]    freq;
    logic [NCH*27-1:0]    tcnt;
    logic [NCH-1:0]       gnt;
    logic                 res_valid;
    logic [CHW-1:0]       res_ch;
    logic [26:0]          res_phase;
    logic                 busy;
    logic                 err;

    phtime_arb #(.NCH(NCH), .CHW(CHW), .LAT(LAT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .freq      (freq),
        .tcnt      (tcnt),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_phase (res_phase),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      due;
        int          ch;
        logic [26:0] ph;
    } exp_t;

    int             checks_total  = 0;
    int             checks_passed = 0;
    longint         cyc = 0;
    int             m_ptr = 0;
    int             m_gch;
    logic [NCH-1:0] m_gnt;
    logic [NCH-1:0] last_gnt = '0;
    bit             m_valid;
    exp_t           exp_q[$];
    exp_t           m_item;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] ref_phase(input logic [26:0] f, input logic [26:0] t);
        longint unsigned p;
        p = longint'(f) * longint'(t);
        p = p % 64'd134217728;
        return p[26:0];
    endfunction

    // Reference model and compare, one step per cycle
    always @(negedge clk) begin
        if (!resetn) begin
            checkOutput("rst_gnt", gnt, 0);
            checkOutput("rst_res_valid", res_valid, 0);
            checkOutput("rst_res_ch", res_ch, 0);
            checkOutput("rst_res_phase", res_phase, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_err", err, 0);
            exp_q.delete();
            m_ptr    = 0;
            last_gnt = '0;
        end else begin
            m_gnt = '0;
            m_gch = -1;
            for (int k = 0; k < NCH; k++) begin
                if (m_gch < 0 && req[(m_ptr + k) % NCH]) begin
                    m_gch = (m_ptr + k) % NCH;
                end
            end
            if (m_gch >= 0) begin
                m_gnt[m_gch] = 1'b1;
            end
            checkOutput("gnt", gnt, m_gnt);
            checkOutput("busy", busy, exp_q.size() != 0);
            m_valid = 1'b0;
            if (exp_q.size() != 0) begin
                if (exp_q[0].due == cyc) begin
                    m_valid = 1'b1;
                end
            end
            checkOutput("res_valid", res_valid, m_valid);
            if (m_valid) begin
                checkOutput("res_ch", res_ch, exp_q[0].ch);
                checkOutput("res_phase", res_phase, exp_q[0].ph);
                void'(exp_q.pop_front());
            end else begin
                checkOutput("res_phase_idle", res_phase, 0);
            end
            checkOutput("err", err, 0);
            if (m_gch >= 0) begin
                m_item.due = cyc + LAT;
                m_item.ch  = m_gch;
                m_item.ph  = ref_phase(freq[27*m_gch +: 27], tcnt[27*m_gch +: 27]);
                exp_q.push_back(m_item);
                m_ptr = (m_gch + 1) % NCH;
            end
            last_gnt = m_gnt;
        end
        cyc++;
    end

    task automatic applyStimulus(input logic [NCH-1:0] r);
        @(posedge clk);
        #1;
        req = r;
    endtask

    task automatic set_ops(input int ch, input logic [26:0] f, input logic [26:0] t);
        freq[27*ch +: 27] = f;
        tcnt[27*ch +: 27] = t;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        req    = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // One isolated request; checks the grant and the result LAT cycles later
    task automatic run_single(input int ch, input logic [26:0] f, input logic [26:0] t,
                              input logic [26:0] exp_ph, input string name);
        logic [NCH-1:0] one;
        one = 1;
        @(posedge clk);
        #1;
        set_ops(ch, f, t);
        req = one << ch;
        @(negedge clk);
        checkOutput({name, "_gnt"}, gnt, one << ch);
        applyStimulus('0);
        repeat (LAT - 1) @(negedge clk);
        checkOutput({name, "_early"}, res_valid, 0);
        @(negedge clk);
        checkOutput({name, "_valid"}, res_valid, 1);
        checkOutput({name, "_ch"}, res_ch, ch);
        checkOutput({name, "_phase"}, res_phase, exp_ph);
    endtask

    function automatic logic [26:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 27'h7FFFFFF;
            1:       return 27'h0;
            2:       return 27'($urandom_range(0, 15));
            default: return 27'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL timeout: bench did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [NCH-1:0] nreq;
        bit             got3;
        bit             prev0;

        resetn = 1'b0;
        req    = '0;
        freq   = '0;
        tcnt   = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        applyStimulus('0);

        // Single request, then the two wrap cases
        run_single(2, 27'h100, 27'h3, 27'h300, "t1");
        run_single(1, 27'h4000000, 27'h3, 27'h4000000, "t3a");
        run_single(1, 27'h7FFFFFF, 27'h7FFFFFF, 27'h0000001, "t3b");

        // All four requests held for 8 cycles starting from ptr 0
        reset_dut();
        for (int i = 0; i < NCH; i++) begin
            set_ops(i, 27'(i + 1), 27'h10);
        end
        applyStimulus('1);
        for (int i = 0; i < 8 + LAT; i++) begin
            @(negedge clk);
            checkOutput("t2_gnt", gnt, (i < 8) ? (32'd1 << (i % NCH)) : 32'd0);
            checkOutput("t2_valid", res_valid, (i >= LAT && i < 8 + LAT) ? 1 : 0);
            if (i >= LAT) begin
                checkOutput("t2_ch", res_ch, (i - LAT) % NCH);
            end
            @(posedge clk);
            #1;
            if (i == 7) req = '0;
        end

        // Fairness: ch0 held, ch3 asks once
        applyStimulus(4'b0001);
        repeat (3) begin
            @(negedge clk);
            checkOutput("t4_solo", gnt, 4'b0001);
        end
        applyStimulus(4'b1001);
        got3  = 1'b0;
        prev0 = 1'b1;
        for (int i = 0; i < NCH && !got3; i++) begin
            @(negedge clk);
            checkOutput("t4_no_b2b", gnt[0] && prev0, 0);
            prev0 = gnt[0];
            got3  = gnt[3];
            @(posedge clk);
            #1;
            if (got3) req[3] = 1'b0;
        end
        checkOutput("t4_ch3_granted", got3, 1);
        applyStimulus('0);
        repeat (LAT + 1) @(negedge clk);

        // Reset while three issues are in flight
        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        applyStimulus(4'b0100);
        applyStimulus('0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2 * LAT) begin
            @(negedge clk);
            checkOutput("t5_valid", res_valid, 0);
            checkOutput("t5_busy", busy, 0);
            checkOutput("t5_err", err, 0);
        end

        // Idle
        repeat (20) begin
            @(negedge clk);
            checkOutput("t6_gnt", gnt, 0);
            checkOutput("t6_valid", res_valid, 0);
            checkOutput("t6_busy", busy, 0);
            checkOutput("t6_err", err, 0);
        end

        // Randomized traffic: requests persist until granted, then drop or re-request
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            nreq = req;
            for (int i = 0; i < NCH; i++) begin
                if (last_gnt[i]) begin
                    nreq[i] = ($urandom_range(0, 2) == 0);
                    if (nreq[i]) set_ops(i, rand_word(), rand_word());
                end else if (!req[i]) begin
                    set_ops(i, rand_word(), rand_word());
                    nreq[i] = ($urandom_range(0, 3) == 0) || (n % 200 > 150);
                end
            end
            if (n % 300 > 280) nreq = nreq & ~(~last_gnt & ~req);
            req = nreq;
        end
        applyStimulus('0);
        repeat (LAT + 2) @(negedge clk);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
